// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: sideband bit positions and default word geometry
package instruction_queue_pkg;
   localparam int WORD_W_DEF  = 16;
   localparam int GROUP_W_DEF = 2;
   localparam int SB_W_DEF    = 6;
   localparam int SB_ADDR_INC = 5;
   localparam int SB_EN_BKP   = 4;
   localparam int SB_OP_MSB   = 3;
   localparam int SB_OP_LSB   = 1;
   localparam int SB_MODE     = 0;
endpackage

// File: rtl/instruction_fifo_mem.sv
// instruction_fifo_mem: DEPTH x W register array, one write port, one async read port
module instruction_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 22
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(negedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: prefetch FIFO feeding a registered execute latch, with
// same-edge bypass when empty; all state moves on the falling clock edge.
module instruction_queue
   import instruction_queue_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int GROUP_W = GROUP_W_DEF,
   parameter int SB_W    = SB_W_DEF,
   parameter int DEPTH   = 4
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       FLUSH,
   input  logic [WORD_W-1:0]          DIN,
   input  logic [SB_W-1:0]            SB_IN,
   input  logic                       DIN_VALID,
   output logic                       DIN_READY,
   input  logic                       EXECUTE,
   output logic [WORD_W-GROUP_W-1:0]  INSTRUCTION,
   output logic [GROUP_W-1:0]         GROUPX,
   output logic [SB_W-1:0]            SB_OUT,
   output logic                       OUT_VALID,
   output logic [$clog2(DEPTH+1)-1:0] COUNT
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = WORD_W + SB_W;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] head, lat;
   logic [CW-1:0] count_nxt;
   logic          empty, push, pop, bypass, starve, fifo_push;
   assign empty     = COUNT == '0;
   assign push      = DIN_VALID & DIN_READY;
   assign pop       = EXECUTE & ~empty;
   assign bypass    = EXECUTE & empty & push;
   assign starve    = EXECUTE & empty & ~push;
   assign fifo_push = push & ~bypass;
   assign count_nxt = COUNT + CW'(fifo_push) - CW'(pop);
   instruction_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
      .clk   (CLK),
      .we    (fifo_push & ~FLUSH),
      .waddr (wr_ptr),
      .wdata ({DIN, SB_IN}),
      .raddr (rd_ptr),
      .rdata (head)
   );
   always_ff @(negedge CLK or posedge RESET)
      if (RESET) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         COUNT     <= '0;
         DIN_READY <= 1'b1;
         lat       <= '0;
         OUT_VALID <= 1'b0;
      end else if (FLUSH) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         COUNT     <= '0;
         DIN_READY <= 1'b1;
         lat       <= '0;
         OUT_VALID <= 1'b0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         COUNT     <= count_nxt;
         DIN_READY <= count_nxt != CW'(DEPTH);
         if (pop | bypass) begin
            lat       <= pop ? head : {DIN, SB_IN};
            OUT_VALID <= 1'b1;
         end else if (starve) OUT_VALID <= 1'b0;
      end
   assign {GROUPX, INSTRUCTION, SB_OUT} = lat;
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Parametrised successor to the single-entry instruction latch.
- Holds up to DEPTH fetched instruction words, each with its debug sideband, in a FIFO.
- Presents the head entry in a registered execute latch, split into GROUPX and INSTRUCTION fields.
- Sits between the memory fetch path and the decoder, so fetch can run ahead of EXECUTE. FLUSH discards prefetched words on jumps and debug breaks.

Parameters:
- WORD_W, 16: instruction word width; GROUPX is the top GROUP_W bits.
- GROUP_W, 2: width of the GROUPX field.
- SB_W, 6: debug sideband width, packed as {ADDR_INC, EN_BKP, OP[2:0], MODE}.
- DEPTH, 4: FIFO entries; must be a power of 2, and at least 2.

Ports:
- CLK  in  1: system clock. All state updates on the falling edge, consistent with the existing latch timing.
- RESET  in  1: asynchronous reset, active-high.
- FLUSH  in  1: discard FIFO contents and invalidate the execute latch.
- DIN  in  WORD_W: fetched instruction word.
- SB_IN  in  SB_W: debug sideband accompanying DIN.
- DIN_VALID  in  1: DIN/SB_IN are valid this cycle.
- DIN_READY  out  1: queue can accept a word (not full); registered, no combinational path from inputs.
- EXECUTE  in  1: decoder consumes the current latch contents; load the next entry.
- INSTRUCTION  out  WORD_W-GROUP_W: latched DIN[WORD_W-GROUP_W-1:0].
- GROUPX  out  GROUP_W: latched DIN[WORD_W-1:WORD_W-GROUP_W].
- SB_OUT  out  SB_W: latched sideband.
- OUT_VALID  out  1: execute latch holds a valid instruction.
- COUNT  out  $clog2(DEPTH+1): FIFO occupancy, excluding the execute latch.

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and COUNT = 0; DIN_READY = 1.
  - INSTRUCTION, GROUPX and SB_OUT = 0; OUT_VALID = 0.
  - FIFO storage is not cleared.
- Push: DIN_VALID & DIN_READY at a falling edge writes {DIN, SB_IN} at the write pointer.
  - Write pointer wraps modulo DEPTH.
  - Push while full (DIN_READY = 0) is ignored; no state change.
- Pop: EXECUTE at a falling edge with COUNT > 0.
  - Head entry is loaded into the execute latch; OUT_VALID <= 1.
  - Read pointer advances and wraps modulo DEPTH.
- Bypass: EXECUTE with COUNT = 0 and a valid push in the same edge.
  - DIN/SB_IN load the execute latch directly; OUT_VALID <= 1.
  - FIFO is unchanged; COUNT stays 0.
  - Zero-cycle latency from fetch to latch.
- Starve: EXECUTE with COUNT = 0 and no push.
  - OUT_VALID <= 0; INSTRUCTION, GROUPX and SB_OUT hold their previous values.
- Simultaneous push and pop with COUNT > 0: both occur and COUNT is unchanged.
  - If full, the push is ignored (DIN_READY = 0), so COUNT becomes DEPTH-1.
- No EXECUTE: the execute latch holds.
  - OUT_VALID only clears on reset, FLUSH or starve.
- FLUSH (synchronous, highest priority after RESET):
  - Pointers and COUNT = 0; OUT_VALID <= 0; execute-latch fields <= 0.
  - Same-edge push and EXECUTE are ignored.
- DIN_READY is registered as (next COUNT != DEPTH).
- Pointer/count arithmetic:
  - Pointers are $clog2(DEPTH) bits, wrapping naturally.
  - COUNT is a separate up/down counter; it never exceeds DEPTH or underflows.
- Latency: a pushed word reaches the execute latch on the first EXECUTE edge at which it is at the head. Minimum is the same edge, via bypass.

Decomposition:
- Shared constants package:
  - Sideband bit positions (SB_ADDR_INC = 5, SB_EN_BKP = 4, SB_OP msb/lsb = 3:1, SB_MODE = 0).
  - Default WORD_W and GROUP_W, shared with the decoder.
- One sub-module: instruction_fifo_mem, a DEPTH x (WORD_W+SB_W) register array with one write port and one async read port.
- Pointers, COUNT, bypass and the execute latch live in the top module.

Test Plan:
- Reset mid-operation: with COUNT = 3 and OUT_VALID = 1, assert RESET between clock edges -> COUNT = 0, OUT_VALID = 0 and INSTRUCTION = 0 immediately, with no clock edge needed.
- Fill (DEPTH = 4): push 0x4001, 0x8002, 0xC003, 0x0004 with no EXECUTE -> COUNT = 4, DIN_READY = 0.
  - Fifth push 0x1234 is ignored.
  - Four EXECUTEs yield GROUPX/INSTRUCTION = 1/0x0001, 2/0x0002, 3/0x0003, 0/0x0004, in order.
- Bypass: empty queue, same edge DIN = 0xBEEF with DIN_VALID and EXECUTE -> GROUPX = 2, INSTRUCTION = 0x3EEF, OUT_VALID = 1, COUNT = 0.
- Starve and wrap: push 6 words interleaved with pops, then EXECUTE on empty -> order preserved across the pointer wrap. Final EXECUTE drops OUT_VALID with INSTRUCTION held.
- Flush vs push: COUNT = 2, then FLUSH with DIN_VALID = 1 and EXECUTE = 1 on the same edge -> COUNT = 0, OUT_VALID = 0, fields = 0, pushed word dropped.
- Sideband: push SB_IN = 6'b101101 with DIN = 0x0100, then EXECUTE -> SB_OUT = 6'b101101.
  - Full with simultaneous push and EXECUTE -> COUNT = 3 and the push is dropped.
